// File: rtl/sync_pkg.sv
// Shared definitions for the RX timing-sync chain (energy, correlation, detect).
// Samples are 21-bit fixed point: 1 sign bit, 8 integer bits, 12 fractional bits.
package sync_pkg;

  localparam int DW     = 21;
  localparam int FRAC_W = 12;

  // Detect FSM encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEARCH  = 2'd1;
  localparam logic [1:0] CONFIRM = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  typedef struct packed {
    logic vld;
    logic hit;
  } stage_t;

endpackage

// File: rtl/ofdm_sync_thresh_cmp.sv
// Threshold compare for sync detect: clamps negative operands to zero, tests
// Corr*8 >= Energy*THRESH_NUM and registers the result as stage 1.
module ofdm_sync_thresh_cmp
  import sync_pkg::*;
#(
  parameter int THRESH_NUM = 6
)(
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          i_en,
  input  logic          i_corr_vld,
  input  logic [DW-1:0] i_corr,
  input  logic          i_eng_vld,
  input  logic [DW-1:0] i_eng,
  output logic          o_vld,
  output logic          o_hit
);

  localparam logic [3:0] TN = 4'(THRESH_NUM);

  logic [DW-1:0] w_corr;
  logic [DW-1:0] w_eng;
  logic [DW+2:0] w_lhs;
  logic [DW+2:0] w_rhs;
  stage_t        r_stg;

  assign w_corr = i_corr[DW-1] ? '0 : i_corr;
  assign w_eng  = i_eng[DW-1]  ? '0 : i_eng;
  assign w_lhs  = {w_corr, 3'b000};
  // THRESH_NUM <= 8 keeps the product inside DW+3 bits
  assign w_rhs  = {3'b000, w_eng} * {{(DW-1){1'b0}}, TN};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stg <= '0;
    end else begin
      r_stg.vld <= i_en & i_corr_vld & i_eng_vld;
      r_stg.hit <= (w_lhs >= w_rhs);
    end
  end

  assign o_vld = r_stg.vld;
  assign o_hit = r_stg.hit;

endmodule

// File: rtl/ofdm_sync_detect_ctrl.sv
// Packet-start detector: confirms a sustained correlation plateau, emits a
// frame-start pulse, then holds off re-detection for a fixed sample count.
module ofdm_sync_detect_ctrl
  import sync_pkg::*;
#(
  parameter int THRESH_NUM  = 6,
  parameter int HIT_COUNT   = 32,
  parameter int HOLDOFF_LEN = 320
)(
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          SearchEn,
  input  logic          CorrEnable,
  input  logic [DW-1:0] CorrData,
  input  logic          EnergyEnable,
  input  logic [DW-1:0] EnergyData,
  output logic          DetectPulse,
  output logic          Locked,
  output logic [15:0]   SampleCnt,
  output logic          AlignErr
);

  localparam logic [7:0]  HIT_TGT = 8'(HIT_COUNT);
  localparam logic [15:0] HOLD_LD = 16'(HOLDOFF_LEN);

  logic        w_stg_vld;
  logic        w_stg_hit;
  logic        w_sample;
  logic        w_misalign;
  logic        w_en_rise;
  logic        w_detect;
  logic [7:0]  w_hit_nxt;

  logic        r_en_d;
  logic [1:0]  r_state;
  logic [7:0]  r_hit_cnt;
  logic [15:0] r_hold;
  logic [15:0] r_sample_cnt;
  logic        r_pulse;
  logic        r_locked;
  logic        r_align_err;

  ofdm_sync_thresh_cmp #(
    .THRESH_NUM (THRESH_NUM)
  ) u_cmp (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .i_en       (SearchEn),
    .i_corr_vld (CorrEnable),
    .i_corr     (CorrData),
    .i_eng_vld  (EnergyEnable),
    .i_eng      (EnergyData),
    .o_vld      (w_stg_vld),
    .o_hit      (w_stg_hit)
  );

  assign w_sample   = CorrEnable & EnergyEnable;
  assign w_misalign = SearchEn & (CorrEnable ^ EnergyEnable);
  assign w_en_rise  = SearchEn & ~r_en_d;
  assign w_hit_nxt  = r_hit_cnt + 8'd1;

  // Plateau confirmed by the staged sample currently presented
  assign w_detect = w_stg_vld & w_stg_hit &
                    (((r_state == SEARCH)  && (HIT_TGT == 8'd1)) ||
                     ((r_state == CONFIRM) && (w_hit_nxt == HIT_TGT)));

  // Sample counter and alignment flag restart when detection is re-armed;
  // a sample or misalignment on the arming cycle itself still counts.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_en_d       <= 1'b0;
      r_sample_cnt <= '0;
      r_align_err  <= 1'b0;
    end else begin
      r_en_d <= SearchEn;
      if (w_en_rise)
        r_sample_cnt <= w_sample ? 16'd1 : 16'd0;
      else if (SearchEn && w_sample)
        r_sample_cnt <= r_sample_cnt + 16'd1;
      if (w_en_rise)
        r_align_err <= w_misalign;
      else if (w_misalign)
        r_align_err <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= IDLE;
      r_hit_cnt <= '0;
      r_hold    <= '0;
      r_pulse   <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (!SearchEn) begin
        r_state   <= IDLE;
        r_hit_cnt <= '0;
        r_hold    <= '0;
        r_locked  <= 1'b0;
      end else if (w_detect) begin
        r_state   <= HOLDOFF;
        r_hit_cnt <= '0;
        r_hold    <= HOLD_LD;
        r_pulse   <= 1'b1;
        r_locked  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_state   <= SEARCH;
            r_hit_cnt <= '0;
          end
          SEARCH: begin
            if (w_stg_vld && w_stg_hit) begin
              r_hit_cnt <= 8'd1;
              r_state   <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (w_stg_vld) begin
              if (!w_stg_hit) begin
                r_hit_cnt <= '0;
                r_state   <= SEARCH;
              end else begin
                r_hit_cnt <= w_hit_nxt;
              end
            end
          end
          HOLDOFF: begin
            // Only valid samples age the holdoff; hit/miss is irrelevant here
            if (w_stg_vld) begin
              if (r_hold <= 16'd1) begin
                r_hold   <= '0;
                r_locked <= 1'b0;
                r_state  <= SEARCH;
              end else begin
                r_hold <= r_hold - 16'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign DetectPulse = r_pulse;
  assign Locked      = r_locked;
  assign SampleCnt   = r_sample_cnt;
  assign AlignErr    = r_align_err;

endmodule

// File: tb/tb_ofdm_sync_detect_ctrl.sv
// Bench for ofdm_sync_detect_ctrl: threshold vector table, directed corner
// sequences and randomized traffic against a sample-level reference model.
module tb_ofdm_sync_detect_ctrl;
  import sync_pkg::*;

  localparam int TB_TN   = 6;
  localparam int TB_HITS = 32;
  localparam int TB_HOLD = 320;

  localparam logic [DW-1:0] E1  = 21'h01000;
  localparam logic [DW-1:0] CH  = 21'h00CCC;
  localparam logic [DW-1:0] CMS = 21'h00800;

  logic          Clk;
  logic          Rst_n;
  logic          SearchEn;
  logic          CorrEnable;
  logic [DW-1:0] CorrData;
  logic          EnergyEnable;
  logic [DW-1:0] EnergyData;
  logic          DetectPulse;
  logic          Locked;
  logic [15:0]   SampleCnt;
  logic          AlignErr;

  ofdm_sync_detect_ctrl dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .SearchEn     (SearchEn),
    .CorrEnable   (CorrEnable),
    .CorrData     (CorrData),
    .EnergyEnable (EnergyEnable),
    .EnergyData   (EnergyData),
    .DetectPulse  (DetectPulse),
    .Locked       (Locked),
    .SampleCnt    (SampleCnt),
    .AlignErr     (AlignErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plateau run length over accepted samples, holdoff as a
  // remaining-sample budget, one-sample staging before a decision is made.
  int m_run, m_hold, m_cnt;
  bit m_locked, m_pulse, m_align, m_enp;
  bit s_vld, s_hit;

  int gstep, npulse, pulse_step, pulse_cnt;

  typedef struct {
    logic [DW-1:0] corr;
    logic [DW-1:0] eng;
    bit            hit;
  } tv_t;
  tv_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (step %0d)", nm, act, exp, gstep);
    end
  endtask

  function automatic bit ref_hit(input logic [DW-1:0] c, input logic [DW-1:0] e);
    longint ci, ei;
    ci = c[DW-1] ? 0 : longint'(c);
    ei = e[DW-1] ? 0 : longint'(e);
    return (ci * 8) >= (ei * TB_TN);
  endfunction

  task automatic model_reset();
    m_run = 0; m_hold = 0; m_cnt = 0;
    m_locked = 0; m_pulse = 0; m_align = 0; m_enp = 0;
    s_vld = 0; s_hit = 0;
  endtask

  task automatic model_edge(input bit en, input bit cv, input logic [DW-1:0] c,
                            input bit ev, input logic [DW-1:0] e);
    m_pulse = 0;
    if (!en) begin
      m_run = 0; m_hold = 0; m_locked = 0;
    end else if (s_vld) begin
      if (m_locked) begin
        m_hold = m_hold - 1;
        if (m_hold == 0) m_locked = 0;
      end else begin
        m_run = s_hit ? m_run + 1 : 0;
        if (m_run == TB_HITS) begin
          m_pulse = 1; m_locked = 1; m_hold = TB_HOLD; m_run = 0;
        end
      end
    end
    s_vld = en && cv && ev;
    s_hit = ref_hit(c, e);
    if (en && !m_enp) begin m_cnt = 0; m_align = 0; end
    if (en && cv && ev) m_cnt = (m_cnt + 1) % 65536;
    if (en && (cv != ev)) m_align = 1;
    m_enp = en;
  endtask

  task automatic step(input bit en, input bit cv, input logic [DW-1:0] c,
                      input bit ev, input logic [DW-1:0] e);
    SearchEn = en; CorrEnable = cv; CorrData = c; EnergyEnable = ev; EnergyData = e;
    @(posedge Clk);
    model_edge(en, cv, c, ev, e);
    @(negedge Clk);
    gstep++;
    if (DetectPulse) begin
      npulse++; pulse_step = gstep; pulse_cnt = int'(SampleCnt);
    end
    chk("m_pulse", 32'(DetectPulse), 32'(m_pulse));
    chk("m_locked", 32'(Locked), 32'(m_locked));
    chk("m_cnt", 32'(SampleCnt), 32'(m_cnt));
    chk("m_align", 32'(AlignErr), 32'(m_align));
  endtask

  task automatic hit_s();  step(1, 1, CH,  1, E1); endtask
  task automatic miss_s(); step(1, 1, CMS, 1, E1); endtask
  task automatic idle_s(input bit en); step(en, 0, '0, 0, '0); endtask

  initial begin
    int p0, s_last, r, ev_i, c_i;
    bit ren, cv, evb;
    logic [DW-1:0] c, e;

    tv[0] = '{21'h00C00,  21'h01000,  1'b1};
    tv[1] = '{21'h00BFF,  21'h01000,  1'b0};
    tv[2] = '{21'h100C00, 21'h01000,  1'b0};
    tv[3] = '{21'h00000,  21'h00000,  1'b1};
    tv[4] = '{21'h00000,  21'h00001,  1'b0};
    tv[5] = '{21'h00800,  21'h101000, 1'b1};
    tv[6] = '{21'h0C0000, 21'h0FFFFF, 1'b1};
    tv[7] = '{21'h0BFFFF, 21'h0FFFFF, 1'b0};
    tv[8] = '{21'h0FFFFF, 21'h0FFFFF, 1'b1};
    tv[9] = '{21'h1FFFFF, 21'h00000,  1'b1};

    gstep = 0; npulse = 0; pulse_step = -1; pulse_cnt = -1;
    model_reset();
    Rst_n = 1'b0; SearchEn = 0; CorrEnable = 0; EnergyEnable = 0;
    CorrData = '0; EnergyData = '0;
    repeat (3) @(negedge Clk);
    chk("rst_pulse", 32'(DetectPulse), 32'd0);
    chk("rst_locked", 32'(Locked), 32'd0);
    chk("rst_cnt", 32'(SampleCnt), 32'd0);
    chk("rst_align", 32'(AlignErr), 32'd0);
    Rst_n = 1'b1;

    // Reset mid-CONFIRM with AlignErr set and ten hits counted
    idle_s(1);
    step(1, 1, CH, 0, E1);
    repeat (10) hit_s();
    chk("pre_rst_cnt", 32'(SampleCnt), 32'd10);
    Rst_n = 1'b0;
    #1;
    chk("async_pulse", 32'(DetectPulse), 32'd0);
    chk("async_locked", 32'(Locked), 32'd0);
    chk("async_cnt", 32'(SampleCnt), 32'd0);
    chk("async_align", 32'(AlignErr), 32'd0);
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    p0 = npulse;
    repeat (40) step(0, 1, CH, 1, E1);
    chk("disabled_pulses", 32'(npulse - p0), 32'd0);

    // Basic detect
    p0 = npulse;
    idle_s(1);
    repeat (32) hit_s();
    s_last = gstep;
    repeat (3) idle_s(1);
    chk("basic_npulse", 32'(npulse - p0), 32'd1);
    chk("basic_latency", 32'(pulse_step - s_last), 32'd1);
    chk("basic_cnt", 32'(pulse_cnt), 32'd32);
    chk("basic_locked", 32'(Locked), 32'd1);

    // Broken plateau
    idle_s(0);
    p0 = npulse;
    idle_s(1);
    repeat (20) hit_s();
    miss_s();
    repeat (32) hit_s();
    s_last = gstep;
    repeat (3) idle_s(1);
    chk("broken_npulse", 32'(npulse - p0), 32'd1);
    chk("broken_latency", 32'(pulse_step - s_last), 32'd1);
    chk("broken_cnt", 32'(pulse_cnt), 32'd53);

    // Threshold table: the vector sample completes a 32-sample run
    foreach (tv[i]) begin
      idle_s(0);
      p0 = npulse;
      repeat (31) hit_s();
      step(1, 1, tv[i].corr, 1, tv[i].eng);
      repeat (3) idle_s(1);
      chk($sformatf("thresh_vec%0d", i), 32'(npulse - p0), 32'(tv[i].hit));
    end

    // Holdoff with gaps in valid
    idle_s(0);
    p0 = npulse;
    idle_s(1);
    repeat (32) hit_s();
    for (int k = 1; k <= TB_HOLD; k++) begin
      if (k % 3 == 0) idle_s(1);
      hit_s();
    end
    chk("hold_locked_last", 32'(Locked), 32'd1);
    idle_s(1);
    chk("hold_unlocked", 32'(Locked), 32'd0);
    repeat (32) hit_s();
    s_last = gstep;
    repeat (2) idle_s(1);
    chk("hold_npulse", 32'(npulse - p0), 32'd2);
    chk("hold_relatency", 32'(pulse_step - s_last), 32'd1);

    // Misalignment, then abort on the confirming edge, then re-arm
    idle_s(0);
    p0 = npulse;
    idle_s(1);
    repeat (5) hit_s();
    step(1, 1, CH, 0, E1);
    chk("mis_align", 32'(AlignErr), 32'd1);
    chk("mis_cnt", 32'(SampleCnt), 32'd5);
    repeat (27) hit_s();
    chk("mis_sticky", 32'(AlignErr), 32'd1);
    idle_s(0);
    repeat (2) idle_s(0);
    chk("abort_npulse", 32'(npulse - p0), 32'd0);
    chk("abort_locked", 32'(Locked), 32'd0);
    idle_s(1);
    chk("rearm_align", 32'(AlignErr), 32'd0);
    chk("rearm_cnt", 32'(SampleCnt), 32'd0);

    // Randomized traffic against the model
    ren = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      r = int'($urandom_range(0, 999));
      if (ren) begin
        if (r < 3) ren = 1'b0;
      end else if (r < 200) ren = 1'b1;
      ev_i = int'($urandom_range(0, 32'h7FFFF));
      e = DW'(ev_i);
      if ($urandom_range(0, 99) < 2) e[DW-1] = 1'b1;
      r = int'($urandom_range(0, 99));
      if (r < 93)      c_i = (ev_i * 6) / 8 + int'($urandom_range(0, 64));
      else if (r < 96) c_i = (ev_i * 6) / 8 - 1;
      else             c_i = int'($urandom_range(0, 32'h1FFFFF));
      c = DW'(c_i);
      r = int'($urandom_range(0, 999));
      cv  = (r < 805) || (r >= 810 && r < 812);
      evb = (r < 800) || (r >= 805 && r < 810);
      step(ren, cv, c, evb, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ofdm_sync_detect_ctrl.md
Name: ofdm_sync_detect_ctrl

Overview:
- Controls packet-start detection in the RX timing-sync chain.
- Takes the time-aligned pair from the sync front end: delayed-correlation magnitude, and the window energy after the 4-cycle alignment delay.
- Runs a threshold/plateau state machine: searches for a sustained correlation plateau, declares a frame start, then holds off re-detection.
- Its outputs gate the downstream CFO estimation and FFT-window logic.

Parameters:
- THRESH_NUM, 6: threshold numerator over 8; a sample hits when Corr*8 >= Energy*THRESH_NUM (default is 0.75).
- HIT_COUNT, 32: consecutive hits needed to confirm the plateau (range 1..255).
- HOLDOFF_LEN, 320: samples ignored after a detection before searching again (range 1..65535).
- DW, 21: data width. Format is 1 sign bit, 8 integer bits, 12 fractional bits.

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- SearchEn  in  1  level; 1 = detection armed, 0 = forces IDLE
- CorrEnable  in  1  correlation sample valid
- CorrData  in  DW  correlation magnitude
- EnergyEnable  in  1  aligned energy sample valid
- EnergyData  in  DW  window energy
- DetectPulse  out  1  one-cycle frame-start pulse
- Locked  out  1  high from detection through the end of holdoff
- SampleCnt  out  16  valid samples counted since SearchEn rose; wraps at 65535
- AlignErr  out  1  sticky; CorrEnable != EnergyEnable seen while SearchEn=1

Behaviour:
- Reset: Rst_n low asynchronously clears all state. FSM=IDLE; DetectPulse, Locked, AlignErr = 0; SampleCnt = 0; hit counter = 0; holdoff counter = 0.
- Valid sample: CorrEnable && EnergyEnable in the same cycle. A cycle with exactly one of them high is not a sample; if SearchEn=1 it sets AlignErr. AlignErr clears only on reset or on a SearchEn 0->1 edge.
- Sign handling: an operand with its sign bit set is treated as 0.
- Compare arithmetic:
  - Left side: {Corr,3'b0}, DW+3 bits.
  - Right side: Energy*THRESH_NUM, DW+3 bits. THRESH_NUM <= 8 guarantees no overflow.
  - Compare is unsigned.
  - Energy=0 with Corr=0 counts as a hit. The plateau count provides the qualification.
- Pipeline:
  - Stage 1 registers hit and valid (edge after the sample).
  - The FSM acts on stage-1 outputs at the next edge.
  - DetectPulse is registered with the FSM transition, so it rises 2 edges after the confirming sample.
- SampleCnt:
  - Increments on each valid sample while SearchEn=1.
  - Clears to 0 on a SearchEn rising edge.
  - Holds while SearchEn=0.
  - 65535 +1 wraps to 0.
- FSM states: IDLE, SEARCH, CONFIRM, HOLDOFF.
  - IDLE: go to SEARCH when SearchEn=1. The hit counter is 0.
  - SEARCH: a staged hit sets hit counter = 1 and goes to CONFIRM. If HIT_COUNT==1, it goes straight to HOLDOFF with DetectPulse.
  - CONFIRM, staged hit: increment the counter. When the count reaches HIT_COUNT: assert DetectPulse for 1 cycle, set Locked=1, load holdoff = HOLDOFF_LEN, go to HOLDOFF.
  - CONFIRM, staged miss: clear the counter and return to SEARCH.
  - CONFIRM, cycles with no staged valid: the count holds.
  - HOLDOFF: decrement on each staged valid. At 0, clear Locked and return to SEARCH. A hit/miss in HOLDOFF is ignored.
- SearchEn=0 in any state: on the next edge go to IDLE, clear Locked and counters, and drop any in-flight pulse. If SearchEn falls on the edge where DetectPulse would fire, the pulse is suppressed.
- Simultaneous case: a confirming hit and the holdoff expiring cannot coincide, because they occur in different states.
- Reset mid-operation: returns to IDLE immediately, with no pulse emitted.

Decomposition:
- Shared package sync_pkg:
  - DW
  - state encoding localparams: IDLE=2'd0, SEARCH=2'd1, CONFIRM=2'd2, HOLDOFF=2'd3
  - the fixed-point format note, shared with the energy and correlation blocks
- One natural sub-module: ofdm_sync_thresh_cmp. It does the sign clamp, scaling and compare, and holds the stage-1 register.

Test Plan:
- Reset/idle: assert Rst_n=0 mid-CONFIRM with hit count 10. Required: all outputs 0 immediately. After release, no DetectPulse with SearchEn=0.
- Basic detect: SearchEn=1, Energy=1.0 (0x01000), Corr=0.8 (0x00CCC) for 32 consecutive valids. Required: exactly one DetectPulse, 2 edges after the 32nd sample; Locked=1; SampleCnt=32 at that point.
- Broken plateau: 20 hits, one miss with Corr=0.5, then 32 hits. Required: a single DetectPulse after the second run only, 53 samples after start.
- Threshold boundary:
  - Energy=0x01000, Corr=0x00C00 (exactly 0.75): hit.
  - Corr=0x00BFF: miss.
  - Negative Corr (sign set): miss.
- Holdoff: after detect, continue hits for 320 samples. Required: Locked falls after the 320th staged valid, then a new detect 32 hits later. Gaps in valid do not advance the holdoff counter.
- Misalignment/abort:
  - CorrEnable=1 with EnergyEnable=0 for one cycle: AlignErr=1 sticky, and no counter change.
  - SearchEn dropped on the confirming edge: no DetectPulse.
  - SearchEn re-raised: AlignErr and SampleCnt clear.
